// File: rtl/prefetcher_axi_mux.sv
// rtl/prefetcher_axi_mux.sv - merges prefetcher slice AXI read ports onto one DDR read master
// Optional feature macro: PREFETCH_AXI_MUX_ERR_EN (adds the sticky err_unrouted output)
module prefetcher_axi_mux #(
    parameter int NUM_SLICES      = 4,
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_SLICES-1:0]                 sl_ar_valid,
    output logic [NUM_SLICES-1:0]                 sl_ar_ready,
    input  logic [NUM_SLICES*ADDR_BITS-1:0]       sl_ar_addr,
    input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] sl_ar_len,
    input  logic [NUM_SLICES*TID_WIDTH-1:0]       sl_ar_id,
    output logic [NUM_SLICES-1:0]                 sl_r_valid,
    input  logic [NUM_SLICES-1:0]                 sl_r_ready,
    output logic [TID_WIDTH-1:0]                  sl_r_id,
    output logic [DATA_WIDTH-1:0]                 sl_r_data,
    output logic                                  sl_r_last,
    output logic                                  m_ar_valid,
    input  logic                                  m_ar_ready,
    output logic [ADDR_BITS-1:0]                  m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
    output logic [TID_WIDTH-1:0]                  m_ar_id,
    input  logic                                  m_r_valid,
    output logic                                  m_r_ready,
    input  logic [TID_WIDTH-1:0]                  m_r_id,
    input  logic [DATA_WIDTH-1:0]                 m_r_data,
    input  logic                                  m_r_last
`ifdef PREFETCH_AXI_MUX_ERR_EN
    ,
    output logic                                  err_unrouted
`endif
);

    localparam int SW = $clog2(NUM_SLICES);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] LAST_SLICE = SW'(NUM_SLICES - 1);

    // Unpacked per-slice views; slice 0 lives in the most significant field
    logic [NUM_SLICES-1:0]      ar_vld;
    logic [ADDR_BITS-1:0]       ar_addr [NUM_SLICES];
    logic [BURST_LEN_WIDTH-1:0] ar_len  [NUM_SLICES];
    logic [TID_WIDTH-1:0]       ar_id   [NUM_SLICES];
    logic [NUM_SLICES-1:0]      r_rdy;

    // Tracking state
    logic [CW-1:0]        out_cnt_q  [NUM_SLICES];
    logic [CW-1:0]        out_cnt_d  [NUM_SLICES];
    logic [TID_WIDTH-1:0] owner_id_q [NUM_SLICES];
    logic [TID_WIDTH-1:0] owner_id_d [NUM_SLICES];
    logic [SW-1:0]        rr_ptr_q, rr_ptr_d;

    // AR output stage registers
    logic                       m_ar_valid_q, m_ar_valid_d;
    logic [ADDR_BITS-1:0]       m_ar_addr_q, m_ar_addr_d;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len_q, m_ar_len_d;
    logic [TID_WIDTH-1:0]       m_ar_id_q, m_ar_id_d;

    logic [NUM_SLICES-1:0] eligible;
    logic                  win_found;
    logic [SW-1:0]         win_idx;
    logic                  stage_free;
    logic                  grant;
    logic                  hit_any;
    logic [SW-1:0]         sel;
    logic                  sel_ready;
    logic                  r_hs;
    logic                  r_last_hs;

    // Split the concatenated slice buses into per-slice fields
    always_comb begin
        for (int i = 0; i < NUM_SLICES; i++) begin
            ar_vld[i]  = sl_ar_valid[NUM_SLICES-1-i];
            ar_addr[i] = sl_ar_addr[(NUM_SLICES-1-i)*ADDR_BITS +: ADDR_BITS];
            ar_len[i]  = sl_ar_len[(NUM_SLICES-1-i)*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
            ar_id[i]   = sl_ar_id[(NUM_SLICES-1-i)*TID_WIDTH +: TID_WIDTH];
            r_rdy[i]   = sl_r_ready[NUM_SLICES-1-i];
        end
    end

    // A slice may request when it has room and its ID is not live on another slice
    always_comb begin
        for (int i = 0; i < NUM_SLICES; i++) begin
            eligible[i] = ar_vld[i] && (out_cnt_q[i] < CNT_MAX);
            for (int j = 0; j < NUM_SLICES; j++) begin
                if (j != i && out_cnt_q[j] != '0 && owner_id_q[j] == ar_id[i]) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    // Round-robin pick: first eligible slice at or after rr_ptr
    always_comb begin
        int slot;
        logic [SW-1:0] slot_idx;
        slot      = 0;
        slot_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            slot     = (int'(rr_ptr_q) + k) % NUM_SLICES;
            slot_idx = SW'(slot);
            if (!win_found && eligible[slot_idx]) begin
                win_found = 1'b1;
                win_idx   = slot_idx;
            end
        end
    end

    assign stage_free = !m_ar_valid_q || m_ar_ready;
    assign grant      = win_found && stage_free;

    // R routing: lowest-index slice whose live owner ID matches the beat
    always_comb begin
        hit_any = 1'b0;
        sel     = '0;
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            if (out_cnt_q[i] != '0 && owner_id_q[i] == m_r_id) begin
                hit_any = 1'b1;
                sel     = SW'(i);
            end
        end
    end

    // Handshake fan-out to slices; unrouted beats are always accepted and dropped
    always_comb begin
        sl_ar_ready = '0;
        sl_r_valid  = '0;
        sel_ready   = 1'b0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            sl_ar_ready[NUM_SLICES-1-i] = grant && (win_idx == SW'(i));
            sl_r_valid[NUM_SLICES-1-i]  = m_r_valid && hit_any && (sel == SW'(i));
            if (sel == SW'(i)) begin
                sel_ready = r_rdy[i];
            end
        end
        m_r_ready = hit_any ? sel_ready : 1'b1;
    end

    assign r_hs      = m_r_valid && m_r_ready;
    assign r_last_hs = r_hs && hit_any && m_r_last;

    assign sl_r_id   = m_r_id;
    assign sl_r_data = m_r_data;
    assign sl_r_last = m_r_last;

    // Per-slice owner and outstanding-count updates; grant and last-beat cancel out
    always_comb begin
        for (int i = 0; i < NUM_SLICES; i++) begin
            out_cnt_d[i]  = out_cnt_q[i];
            owner_id_d[i] = owner_id_q[i];
            if (grant && win_idx == SW'(i)) begin
                owner_id_d[i] = ar_id[i];
            end
            case ({grant && win_idx == SW'(i), r_last_hs && sel == SW'(i)})
                2'b10:   out_cnt_d[i] = out_cnt_q[i] + CW'(1);
                2'b01:   out_cnt_d[i] = out_cnt_q[i] - CW'(1);
                default: out_cnt_d[i] = out_cnt_q[i];
            endcase
        end
    end

    // AR output stage: load on grant, drop valid when accepted, otherwise hold
    always_comb begin
        m_ar_valid_d = m_ar_valid_q;
        m_ar_addr_d  = m_ar_addr_q;
        m_ar_len_d   = m_ar_len_q;
        m_ar_id_d    = m_ar_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant) begin
            m_ar_valid_d = 1'b1;
            m_ar_addr_d  = ar_addr[win_idx];
            m_ar_len_d   = ar_len[win_idx];
            m_ar_id_d    = ar_id[win_idx];
            rr_ptr_d     = (win_idx == LAST_SLICE) ? '0 : win_idx + SW'(1);
        end else if (m_ar_ready) begin
            m_ar_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLICES; i++) begin
                out_cnt_q[i]  <= '0;
                owner_id_q[i] <= '0;
            end
            rr_ptr_q     <= '0;
            m_ar_valid_q <= 1'b0;
            m_ar_addr_q  <= '0;
            m_ar_len_q   <= '0;
            m_ar_id_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SLICES; i++) begin
                out_cnt_q[i]  <= out_cnt_d[i];
                owner_id_q[i] <= owner_id_d[i];
            end
            rr_ptr_q     <= rr_ptr_d;
            m_ar_valid_q <= m_ar_valid_d;
            m_ar_addr_q  <= m_ar_addr_d;
            m_ar_len_q   <= m_ar_len_d;
            m_ar_id_q    <= m_ar_id_d;
        end
    end

    assign m_ar_valid = m_ar_valid_q;
    assign m_ar_addr  = m_ar_addr_q;
    assign m_ar_len   = m_ar_len_q;
    assign m_ar_id    = m_ar_id_q;

`ifdef PREFETCH_AXI_MUX_ERR_EN
    logic err_q, err_d;

    // Sticky flag for any accepted beat that matched no live burst
    always_comb begin
        err_d = err_q || (r_hs && !hit_any);
    end

    // Error flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_unrouted = err_q;
`endif

endmodule

// File: tb/tb_prefetcher_axi_mux.sv
// tb/tb_prefetcher_axi_mux.sv - randomized and directed check of prefetcher_axi_mux against a reference model
module tb_prefetcher_axi_mux;

    localparam int N    = 4;
    localparam int MAXO = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   sl_ar_valid, sl_ar_ready, sl_r_valid, sl_r_ready;
    logic [N*64-1:0] sl_ar_addr;
    logic [N*8-1:0] sl_ar_len, sl_ar_id;
    logic [7:0]     sl_r_id;
    logic [63:0]    sl_r_data;
    logic           sl_r_last;
    logic           m_ar_valid, m_ar_ready;
    logic [63:0]    m_ar_addr;
    logic [7:0]     m_ar_len, m_ar_id;
    logic           m_r_valid, m_r_ready;
    logic [7:0]     m_r_id;
    logic [63:0]    m_r_data;
    logic           m_r_last;
`ifdef PREFETCH_AXI_MUX_ERR_EN
    logic           err_unrouted;
`endif

    // Per-slice stimulus
    logic        t_v  [N];
    logic [63:0] t_a  [N];
    logic [7:0]  t_l  [N];
    logic [7:0]  t_id [N];
    logic        t_rr [N];

    // Reference model
    int          m_cnt [N];
    logic [7:0]  m_own [N];
    int          m_rr;
    logic        m_mav;
    logic [63:0] m_maddr;
    logic [7:0]  m_mlen, m_mid;
    logic        m_err;

    int n_cmp = 0;
    int n_bad = 0;
    int last_grant;
    logic [N-1:0] obs_ardy, obs_rv;
    logic obs_mrr;

    prefetcher_axi_mux #(
        .NUM_SLICES(N), .ADDR_BITS(64), .BURST_LEN_WIDTH(8),
        .TID_WIDTH(8), .DATA_WIDTH(64), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .sl_ar_valid(sl_ar_valid), .sl_ar_ready(sl_ar_ready),
        .sl_ar_addr(sl_ar_addr), .sl_ar_len(sl_ar_len), .sl_ar_id(sl_ar_id),
        .sl_r_valid(sl_r_valid), .sl_r_ready(sl_r_ready),
        .sl_r_id(sl_r_id), .sl_r_data(sl_r_data), .sl_r_last(sl_r_last),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_last(m_r_last)
`ifdef PREFETCH_AXI_MUX_ERR_EN
        , .err_unrouted(err_unrouted)
`endif
    );

    initial forever #5 clk = ~clk;

    always_comb begin
        for (int s = 0; s < N; s++) begin
            sl_ar_valid[N-1-s]          = t_v[s];
            sl_ar_addr[(N-1-s)*64 +: 64] = t_a[s];
            sl_ar_len[(N-1-s)*8 +: 8]    = t_l[s];
            sl_ar_id[(N-1-s)*8 +: 8]     = t_id[s];
            sl_r_ready[N-1-s]           = t_rr[s];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mdl_winner();
        int s;
        bit ok;
        for (int k = 0; k < N; k++) begin
            s  = (m_rr + k) % N;
            ok = t_v[s] && (m_cnt[s] < MAXO);
            for (int j = 0; j < N; j++)
                if (j != s && m_cnt[j] > 0 && m_own[j] == t_id[s]) ok = 0;
            if (ok) return s;
        end
        return -1;
    endfunction

    function automatic int mdl_route(input logic [7:0] rid);
        for (int i = 0; i < N; i++)
            if (m_cnt[i] > 0 && m_own[i] == rid) return i;
        return -1;
    endfunction

    task automatic clear_inputs();
        for (int s = 0; s < N; s++) begin
            t_v[s] = 0; t_a[s] = '0; t_l[s] = '0; t_id[s] = '0; t_rr[s] = 1;
        end
        m_ar_ready = 1; m_r_valid = 0; m_r_id = '0; m_r_data = '0; m_r_last = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        #2;
        check("rst_m_ar_valid", m_ar_valid, 0);
        check("rst_m_ar_addr", m_ar_addr, 0);
        check("rst_m_ar_len", m_ar_len, 0);
        check("rst_m_ar_id", m_ar_id, 0);
        check("rst_sl_ar_ready", sl_ar_ready, 0);
        check("rst_sl_r_valid", sl_r_valid, 0);
        check("rst_m_r_ready", m_r_ready, 1);
`ifdef PREFETCH_AXI_MUX_ERR_EN
        check("rst_err", err_unrouted, 0);
`endif
        for (int s = 0; s < N; s++) begin m_cnt[s] = 0; m_own[s] = '0; end
        m_rr = 0; m_mav = 0; m_maddr = '0; m_mlen = '0; m_mid = '0; m_err = 0;
        @(posedge clk);
        #1 reset = 0;
    endtask

    // One clock: check combinational outputs at negedge, advance model at posedge, check registers after
    task automatic cycle();
        int w, r;
        logic [N-1:0] e_ardy, e_rv;
        logic e_mrr;
        @(negedge clk);
        w = (!m_mav || m_ar_ready) ? mdl_winner() : -1;
        r = mdl_route(m_r_id);
        e_ardy = '0;
        e_rv   = '0;
        if (w >= 0) e_ardy[N-1-w] = 1'b1;
        if (r >= 0) e_rv[N-1-r] = m_r_valid;
        e_mrr = (r >= 0) ? t_rr[r] : 1'b1;
        obs_ardy = sl_ar_ready; obs_rv = sl_r_valid; obs_mrr = m_r_ready;
        check("sl_ar_ready", sl_ar_ready, e_ardy);
        check("sl_r_valid", sl_r_valid, e_rv);
        check("m_r_ready", m_r_ready, e_mrr);
        check("sl_r_data", {sl_r_data[31:0], sl_r_id, 23'd0, sl_r_last}, {m_r_data[31:0], m_r_id, 23'd0, m_r_last});
        last_grant = w;
        @(posedge clk);
        if (w >= 0) begin
            m_mav = 1; m_maddr = t_a[w]; m_mlen = t_l[w]; m_mid = t_id[w];
            m_own[w] = t_id[w]; m_cnt[w]++; m_rr = (w + 1) % N;
        end else if (m_ar_ready) begin
            m_mav = 0;
        end
        if (m_r_valid && e_mrr) begin
            if (r >= 0) begin
                if (m_r_last) m_cnt[r]--;
            end else begin
                m_err = 1;
            end
        end
        #1;
        check("m_ar_valid", m_ar_valid, m_mav);
        check("m_ar_addr", m_ar_addr, m_maddr);
        check("m_ar_len", m_ar_len, m_mlen);
        check("m_ar_id", m_ar_id, m_mid);
`ifdef PREFETCH_AXI_MUX_ERR_EN
        check("err_unrouted", err_unrouted, m_err);
`endif
    endtask

    initial begin
        int order [5];
        int s;
        order = '{0, 1, 2, 3, 0};
        reset = 0;
        clear_inputs();
        #1;
        do_reset();

        // Single request from slice 1 and its four-beat burst
        t_v[1] = 1; t_a[1] = 64'h1000; t_l[1] = 8'd3; t_id[1] = 8'd5;
        cycle();
        check("t1_ardy", obs_ardy, 4'b0100);
        check("t1_valid", m_ar_valid, 1);
        check("t1_addr", m_ar_addr, 64'h1000);
        check("t1_len", m_ar_len, 3);
        check("t1_id", m_ar_id, 5);
        t_v[1] = 0;
        m_r_valid = 1; m_r_id = 8'd5;
        for (int b = 0; b < 4; b++) begin
            m_r_last = (b == 3); m_r_data = {$urandom, $urandom};
            cycle();
            check("t1_route", obs_rv, 4'b0100);
        end
        m_r_last = 0;
        for (int i = 0; i < N; i++) t_rr[i] = 0;
        cycle();
        check("t1_drained_rv", obs_rv, 4'b0000);
        check("t1_drained_rdy", obs_mrr, 1);
        m_r_valid = 0;
        for (int i = 0; i < N; i++) t_rr[i] = 1;

        // Round-robin order with all slices requesting
        do_reset();
        for (int i = 0; i < N; i++) begin
            t_v[i] = 1; t_id[i] = 8'h10 + 8'(i); t_a[i] = {$urandom, $urandom}; t_l[i] = 8'(i);
        end
        for (int g = 0; g < 5; g++) begin
            cycle();
            check("t2_order", m_ar_id, 8'h10 + 8'(order[g]));
        end

        // Backpressure: payload holds and no slice is readied
        m_ar_ready = 0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("t3_ardy", obs_ardy, 4'b0000);
            check("t3_hold", m_ar_id, 8'h10);
        end
        m_ar_ready = 1;
        for (int i = 0; i < N; i++) t_v[i] = 0;
        cycle();

        // Reset mid-operation, then a stale beat is dropped
        do_reset();
        for (int i = 0; i < N; i++) t_rr[i] = 0;
        m_r_valid = 1; m_r_id = 8'h10; m_r_last = 1;
        cycle();
        check("t4_stale_rv", obs_rv, 4'b0000);
        check("t4_stale_rdy", obs_mrr, 1);
        m_r_valid = 0; m_r_last = 0;
        for (int i = 0; i < N; i++) t_rr[i] = 1;

        // ID conflict: slice 2 waits for slice 0's burst on id 7
        t_v[0] = 1; t_id[0] = 8'd7; t_a[0] = 64'h2000;
        cycle();
        check("t4_g0", obs_ardy, 4'b1000);
        t_v[0] = 0; t_v[2] = 1; t_id[2] = 8'd7; t_a[2] = 64'h3000;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("t4_stall", obs_ardy, 4'b0000);
        end
        m_r_valid = 1; m_r_id = 8'd7; m_r_last = 0;
        cycle();
        check("t4_route0", obs_rv, 4'b1000);
        check("t4_stall_beat", obs_ardy, 4'b0000);
        m_r_last = 1;
        cycle();
        check("t4_stall_last", obs_ardy, 4'b0000);
        m_r_valid = 0; m_r_last = 0;
        cycle();
        check("t4_g2", obs_ardy, 4'b0010);
        check("t4_g2_addr", m_ar_addr, 64'h3000);
        t_v[2] = 0;

        // Outstanding limit on slice 3
        do_reset();
        t_v[3] = 1; t_id[3] = 8'd9;
        cycle(); check("t5_g1", obs_ardy, 4'b0001);
        cycle(); check("t5_g2", obs_ardy, 4'b0001);
        cycle(); check("t5_full1", obs_ardy, 4'b0000);
        cycle(); check("t5_full2", obs_ardy, 4'b0000);
        m_r_valid = 1; m_r_id = 8'd9; m_r_last = 0;
        cycle(); check("t5_beat", obs_ardy, 4'b0000); check("t5_route", obs_rv, 4'b0001);
        m_r_last = 1;
        cycle(); check("t5_last", obs_ardy, 4'b0000);
        m_r_valid = 0; m_r_last = 0;
        cycle(); check("t5_g3", obs_ardy, 4'b0001);
        // Grant and last beat together leave the count unchanged
        m_r_valid = 1; m_r_last = 1;
        cycle(); check("t5_dec", obs_ardy, 4'b0000);
        cycle(); check("t5_both", obs_ardy, 4'b0001);
        m_r_valid = 0; m_r_last = 0;
        cycle(); check("t5_g4", obs_ardy, 4'b0001);
        cycle(); check("t5_full3", obs_ardy, 4'b0000);
        t_v[3] = 0;

        // Unrouted beat
        for (int i = 0; i < N; i++) t_rr[i] = 0;
        m_r_valid = 1; m_r_id = 8'h3F;
        cycle();
        check("t6_rv", obs_rv, 4'b0000);
        check("t6_rdy", obs_mrr, 1);
`ifdef PREFETCH_AXI_MUX_ERR_EN
        check("t6_err", err_unrouted, 1);
`endif
        m_r_valid = 0;
        for (int i = 0; i < N; i++) t_rr[i] = 1;

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                t_v[i]  = ($urandom_range(0, 2) != 0);
                t_id[i] = 8'($urandom_range(1, 6));
                t_a[i]  = {$urandom, $urandom};
                t_l[i]  = 8'($urandom_range(0, 255));
                t_rr[i] = ($urandom_range(0, 3) != 0);
            end
            m_ar_ready = ($urandom_range(0, 3) != 0);
            m_r_valid  = ($urandom_range(0, 1) != 0);
            s = $urandom_range(0, N - 1);
            m_r_id   = ($urandom_range(0, 3) != 0 && m_cnt[s] > 0) ? m_own[s] : 8'($urandom_range(1, 7));
            m_r_last = ($urandom_range(0, 1) != 0);
            m_r_data = {$urandom, $urandom};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prefetcher_axi_mux.md
# prefetcher_axi_mux

Merges the DDR-side read interfaces of NUM_SLICES prefetcher slices onto one AXI read master toward DDR. The AR side uses round-robin arbitration behind a registered output stage. The R side routes each returning beat back to the slice that owns its ID. Each slice's controller m_ar_*/m_r_* ports connect to the sl_* ports; the m_* ports go to the DDR interconnect.

## Interface
- NUM_SLICES, 4: number of prefetcher slices (≥2)
- ADDR_BITS, 64: address width
- BURST_LEN_WIDTH, 8: AR len width
- TID_WIDTH, 8: AXI ID width
- DATA_WIDTH, 64: R data width
- MAX_OUTSTANDING, 8: per-slice outstanding-burst limit (≤255)

Ports; per-slice buses are concatenated, with slice 0 in the most significant field:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sl_ar_valid  in  NUM_SLICES  slice AR valid
- sl_ar_ready  out  NUM_SLICES  slice AR ready
- sl_ar_addr  in  NUM_SLICES*ADDR_BITS  slice AR address
- sl_ar_len  in  NUM_SLICES*BURST_LEN_WIDTH  slice AR len
- sl_ar_id  in  NUM_SLICES*TID_WIDTH  slice AR id
- sl_r_valid  out  NUM_SLICES  routed R valid
- sl_r_ready  in  NUM_SLICES  slice R ready
- sl_r_id, sl_r_data, sl_r_last  out  TID_WIDTH / DATA_WIDTH / 1  R payload, broadcast to all slices
- m_ar_valid, m_ar_ready  out/in  1  DDR AR handshake
- m_ar_addr, m_ar_len, m_ar_id  out  ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH  DDR AR payload, registered
- m_r_valid, m_r_ready  in/out  1  DDR R handshake
- m_r_id, m_r_data, m_r_last  in  TID_WIDTH / DATA_WIDTH / 1  DDR R payload
- err_unrouted  out  1  sticky flag; present only with PREFETCH_AXI_MUX_ERR_EN

## Operation
- Per-slice state:
  - owner_id: TID_WIDTH bits, loaded on each AR grant
  - out_cnt: counts outstanding bursts, 0..MAX_OUTSTANDING
- Slice i is eligible when all of the following hold:
  - sl_ar_valid[i]
  - out_cnt[i] < MAX_OUTSTANDING
  - no other slice j≠i has out_cnt[j]>0 with owner_id[j]==sl_ar_id[i] (ID-conflict stall)
- Arbitration is round-robin:
  - Search starts at rr_ptr and the first eligible slice wins.
  - On a grant, rr_ptr moves to winner+1 mod NUM_SLICES.
- Output stage is free when ~m_ar_valid | m_ar_ready.
- sl_ar_ready[i] = winner==i & stage free. This is combinational from valid; it is permitted.
- On a slice handshake:
  - payload is loaded into the m_ar_* registers
  - m_ar_valid is set
  - owner_id[i] is loaded
  - out_cnt[i] is incremented
- While m_ar_valid & ~m_ar_ready, the m_ar_* registers hold stable.
- R routing:
  - hit[i] = out_cnt[i]>0 & owner_id[i]==m_r_id
  - The lowest-index hit is selected.
  - sl_r_valid[sel] = m_r_valid, and m_r_ready = sl_r_ready[sel].
  - The ID-conflict rule guarantees at most one hit.
- No hit: m_r_ready=1 and the beat is dropped.
- A handshake with m_r_last decrements out_cnt[sel].
- A grant and a last-beat on the same slice in the same cycle leave out_cnt unchanged.

## Timing
- Reset values:
  - m_ar_valid=0 and m_ar_* payload=0
  - all out_cnt=0, owner_id=0, rr_ptr=0
  - sl_ar_ready=0 and sl_r_valid=0 (combinational, with no valid inputs)
  - err_unrouted=0
- AR latency: slice handshake at cycle T gives m_ar_valid=1 at T+1. Back-to-back grants are possible every cycle while m_ar_ready=1.
- R latency: 0 cycles, purely combinational in both directions.
- Reset mid-operation clears all tracking. Later R beats for pre-reset bursts are dropped as unrouted.
- out_cnt never wraps: a slice at MAX_OUTSTANDING is not eligible.

## Configuration
- PREFETCH_AXI_MUX_ERR_EN defined:
  - err_unrouted port exists
  - it sets on any m_r handshake with no hit and stays set until reset
- Undefined: the port is absent and unrouted beats are dropped silently. Routing behaviour is otherwise identical.

## Test plan
- Reset, then slice 1 requests addr 0x1000, len 3, id 5 → m_ar_valid=1 next cycle with the same payload; out_cnt[1]=1; 4 R beats with id 5 reach only sl_r_valid[1]; out_cnt[1]=0 after the last beat.
- All 4 slices hold valid with distinct ids and m_ar_ready=1 → grants in order 0,1,2,3,0, one per cycle.
- m_ar_ready=0 for 5 cycles → m_ar_* stable; all sl_ar_ready=0.
- Slices 0 and 2 both use id 7 while slice 0 has an outstanding burst → slice 2 stalls until slice 0's last beat, then is granted.
- MAX_OUTSTANDING=2, slice 3 issues 3 ARs with no R → the third is held; it is granted the cycle after the first last-beat.
- R beat with id 0x3F and no owner → m_r_ready=1, no sl_r_valid; err_unrouted=1 with ERR_EN defined, port absent without it.
